// File: rtl/serial_to_parallel_deser.sv
// Double-buffered word-to-frame deserialiser with valid/ready on both sides and partial-frame flush.
// Optional STP_FRAME_CNT_EN adds a 16-bit count of frames loaded into the output register.
module serial_to_parallel_deser #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 8,
   localparam int CW = $clog2(DEPTH + 1)
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic                   in_valid,
   input  logic [WIDTH-1:0]       in_data,
   output logic                   in_ready,
   input  logic                   flush,
   output logic                   out_valid,
   input  logic                   out_ready,
   output logic [WIDTH*DEPTH-1:0] out_data,
   output logic [CW-1:0]          out_count
`ifdef STP_FRAME_CNT_EN
   ,
   output logic [15:0]            frame_cnt
`endif
);

   localparam int IW = $clog2(DEPTH);
   localparam int FW = WIDTH * DEPTH;

   logic [IW-1:0] cnt_q, cnt_d;
   logic [FW-1:0] asm_q, asm_d;
   logic [FW-1:0] out_data_q, out_data_d;
   logic [CW-1:0] out_count_q, out_count_d;
   logic          out_valid_q, out_valid_d;
   logic          flush_pend_q, flush_pend_d;

   logic          out_free;
   logic          last_lane;
   logic          accept;
   logic          full;
   logic          do_flush;
   logic          load;
   logic [CW-1:0] partial;
   logic [FW-1:0] asm_with;

   always_comb begin
      out_free  = !out_valid_q || out_ready;
      last_lane = (cnt_q == IW'(DEPTH - 1));
      in_ready  = !reset && (!last_lane || out_free);
      accept    = in_valid && in_ready;

      // Assembled lanes including the word accepted this cycle, so a load captures it.
      asm_with = asm_q;
      for (int unsigned k = 0; k < DEPTH; k++) begin
         if (accept && (cnt_q == IW'(k))) begin
            asm_with[k*WIDTH +: WIDTH] = in_data;
         end
      end

      partial  = CW'(cnt_q) + CW'(accept);
      full     = accept && last_lane;
      do_flush = (flush || flush_pend_q) && (partial != '0) && out_free && !full;
      load     = full || do_flush;

      asm_d        = load ? '0 : asm_with;
      cnt_d        = load ? '0 : (accept ? cnt_q + IW'(1) : cnt_q);
      flush_pend_d = !load && (flush_pend_q || (flush && (partial != '0)));

      out_data_d  = out_data_q;
      out_count_d = out_count_q;
      out_valid_d = out_valid_q;
      if (load) begin
         out_data_d  = asm_with;
         out_count_d = full ? CW'(DEPTH) : partial;
         out_valid_d = 1'b1;
      end else if (out_ready) begin
         out_valid_d = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         cnt_q        <= '0;
         asm_q        <= '0;
         out_data_q   <= '0;
         out_count_q  <= '0;
         out_valid_q  <= 1'b0;
         flush_pend_q <= 1'b0;
      end else begin
         cnt_q        <= cnt_d;
         asm_q        <= asm_d;
         out_data_q   <= out_data_d;
         out_count_q  <= out_count_d;
         out_valid_q  <= out_valid_d;
         flush_pend_q <= flush_pend_d;
      end
   end

   assign out_valid = out_valid_q;
   assign out_data  = out_data_q;
   assign out_count = out_count_q;

`ifdef STP_FRAME_CNT_EN
   logic [15:0] frame_cnt_q, frame_cnt_d;

   always_comb begin
      frame_cnt_d = load ? frame_cnt_q + 16'd1 : frame_cnt_q;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         frame_cnt_q <= '0;
      end else begin
         frame_cnt_q <= frame_cnt_d;
      end
   end

   assign frame_cnt = frame_cnt_q;
`endif

endmodule

// File: tb/tb_serial_to_parallel_deser.sv
// Bench for serial_to_parallel_deser: queue-based frame model checked every cycle,
// plus directed scenarios with literal expectations.
module tb_serial_to_parallel_deser;

   localparam int WIDTH = 8;
   localparam int DEPTH = 8;
   localparam int CW    = $clog2(DEPTH + 1);

   logic                   clk = 1'b0;
   logic                   reset;
   logic                   in_valid;
   logic [WIDTH-1:0]       in_data;
   logic                   in_ready;
   logic                   flush;
   logic                   out_valid;
   logic                   out_ready;
   logic [WIDTH*DEPTH-1:0] out_data;
   logic [CW-1:0]          out_count;
`ifdef STP_FRAME_CNT_EN
   logic [15:0]            frame_cnt;
`endif

   int n_cmp  = 0;
   int n_fail = 0;

   serial_to_parallel_deser #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
      .clk       (clk),
      .reset     (reset),
      .in_valid  (in_valid),
      .in_data   (in_data),
      .in_ready  (in_ready),
      .flush     (flush),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_data  (out_data),
      .out_count (out_count)
`ifdef STP_FRAME_CNT_EN
      ,
      .frame_cnt (frame_cnt)
`endif
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // Model: a queue of words waiting for a frame, plus the frame held for the consumer.
   logic [WIDTH-1:0] mq[$];
   logic             m_valid = 1'b0;
   logic [63:0]      m_data  = '0;
   int               m_count = 0;
   logic             m_pend  = 1'b0;
   logic             m_known = 1'b0;
   int               m_pops  = 0;
   logic [15:0]      m_fcnt  = '0;

   always @(posedge clk) begin
      logic free, rdy, emit;
      int   n;
      if (reset) begin
         mq.delete();
         m_valid = 1'b0;
         m_data  = '0;
         m_count = 0;
         m_pend  = 1'b0;
         m_known = 1'b1;
         m_fcnt  = '0;
      end else begin
         free = !m_valid || out_ready;
         rdy  = (mq.size() != DEPTH - 1) || free;
         if (in_valid && rdy) mq.push_back(in_data);
         emit = 1'b0;
         n    = mq.size();
         if (n == DEPTH) begin
            emit = 1'b1;
         end else if ((flush || m_pend) && n > 0) begin
            if (free) emit = 1'b1;
            else      m_pend = 1'b1;
         end
         if (m_valid && out_ready) begin
            m_pops++;
            m_valid = 1'b0;
         end
         if (emit) begin
            m_data = '0;
            for (int i = 0; i < n; i++) m_data[i*WIDTH +: WIDTH] = mq[i];
            m_count = n;
            m_valid = 1'b1;
            m_known = 1'b1;
            m_pend  = 1'b0;
            m_fcnt  = m_fcnt + 16'd1;
            mq.delete();
         end
      end
   end

   always @(negedge clk) begin
      logic exp_rdy;
      if (reset !== 1'bx) begin
         exp_rdy = !reset && ((mq.size() != DEPTH - 1) || !m_valid || out_ready);
         check("in_ready", {63'd0, in_ready}, {63'd0, exp_rdy});
         check("out_valid", {63'd0, out_valid}, {63'd0, m_valid});
         if (m_valid || m_known) begin
            check("out_data", out_data, m_data);
            check("out_count", 64'(out_count), 64'(m_count));
         end
`ifdef STP_FRAME_CNT_EN
         check("frame_cnt", 64'(frame_cnt), 64'(m_fcnt));
`endif
      end
   end

   // Present inputs, let one rising edge sample them, return 1 time unit after it.
   task automatic step(input logic v, input logic [7:0] d, input logic f, input logic r);
      in_valid  = v;
      in_data   = d;
      flush     = f;
      out_ready = r;
      @(posedge clk);
      #1;
   endtask

   initial begin
      int pops0;
      reset = 1'b1; in_valid = 1'b0; in_data = '0; flush = 1'b0; out_ready = 1'b1;
      @(posedge clk); #1;
      step(1'b1, 8'hEE, 1'b0, 1'b1);
      check("t1_ready_in_reset", {63'd0, in_ready}, 64'd0);
      reset = 1'b0;
      step(1'b0, 8'h00, 1'b0, 1'b1);
      check("t1_valid", {63'd0, out_valid}, 64'd0);
      check("t1_data", out_data, 64'd0);
      check("t1_count", 64'(out_count), 64'd0);
      check("t1_ready", {63'd0, in_ready}, 64'd1);

      // T2
      for (int i = 1; i <= 8; i++) step(1'b1, 8'(i), 1'b0, 1'b1);
      check("t2_valid", {63'd0, out_valid}, 64'd1);
      check("t2_data", out_data, 64'h0807060504030201);
      check("t2_count", 64'(out_count), 64'd8);
      step(1'b0, 8'h00, 1'b0, 1'b1);

      // T3
      pops0 = m_pops;
      for (int i = 0; i < 24; i++) begin
         step(1'b1, 8'(8'h40 + i), 1'b0, 1'b1);
         check("t3_ready", {63'd0, in_ready}, 64'd1);
      end
      check("t3_last", out_data, 64'h5756555453525150);
      step(1'b0, 8'h00, 1'b0, 1'b1);
      check("t3_frames", 64'(m_pops - pops0), 64'd3);

      // T4
      for (int k = 0; k < 8; k++) step(1'b1, 8'(8'h30 + k), 1'b0, 1'b1);
      for (int k = 8; k < 15; k++) step(1'b1, 8'(8'h30 + k), 1'b0, 1'b0);
      for (int s = 0; s < 2; s++) begin
         step(1'b1, 8'h3F, 1'b0, 1'b0);
         check("t4_stall", {63'd0, in_ready}, 64'd0);
         check("t4_hold", out_data, 64'h3736353433323130);
      end
      step(1'b1, 8'h3F, 1'b0, 1'b1);
      check("t4_valid", {63'd0, out_valid}, 64'd1);
      check("t4_frame2", out_data, 64'h3F3E3D3C3B3A3938);
      step(1'b0, 8'h00, 1'b0, 1'b1);

      // T5
      step(1'b1, 8'hA1, 1'b0, 1'b1);
      step(1'b1, 8'hA2, 1'b0, 1'b1);
      step(1'b1, 8'hA3, 1'b0, 1'b1);
      step(1'b0, 8'h00, 1'b1, 1'b1);
      check("t5_data", out_data, 64'h0000000000A3A2A1);
      check("t5_count", 64'(out_count), 64'd3);
      step(1'b1, 8'hB1, 1'b0, 1'b1);
      step(1'b1, 8'hB2, 1'b0, 1'b1);
      step(1'b1, 8'hB3, 1'b0, 1'b1);
      step(1'b1, 8'hB4, 1'b1, 1'b1);
      check("t5_data4", out_data, 64'h00000000B4B3B2B1);
      check("t5_count4", 64'(out_count), 64'd4);
      for (int k = 0; k < 8; k++) step(1'b1, 8'(8'h60 + k), (k == 7), 1'b1);
      check("t5_full_flush", 64'(out_count), 64'd8);
      step(1'b0, 8'h00, 1'b1, 1'b1);
      check("t5_empty_flush", {63'd0, out_valid}, 64'd0);

      // T6: pending flush released by out_ready
      for (int k = 0; k < 8; k++) step(1'b1, 8'(8'hC0 + k), 1'b0, 1'b0);
      step(1'b1, 8'hD0, 1'b0, 1'b0);
      step(1'b1, 8'hD1, 1'b0, 1'b0);
      step(1'b0, 8'h00, 1'b1, 1'b0);
      step(1'b0, 8'h00, 1'b0, 1'b0);
      check("t6_hold", out_data, 64'hC7C6C5C4C3C2C1C0);
      step(1'b0, 8'h00, 1'b0, 1'b1);
      check("t6_valid", {63'd0, out_valid}, 64'd1);
      check("t6_data", out_data, 64'h000000000000D1D0);
      check("t6_count", 64'(out_count), 64'd2);
      step(1'b0, 8'h00, 1'b0, 1'b1);

      // Pending flush overtaken by a completing frame
      for (int k = 0; k < 8; k++) step(1'b1, 8'(8'hE0 + k), 1'b0, 1'b0);
      for (int k = 0; k < 7; k++) step(1'b1, 8'(8'hF0 + k), (k == 0), 1'b0);
      step(1'b1, 8'hF7, 1'b0, 1'b1);
      check("t6_full_count", 64'(out_count), 64'd8);
      check("t6_full_data", out_data, 64'hF7F6F5F4F3F2F1F0);
      step(1'b0, 8'h00, 1'b0, 1'b1);
      step(1'b1, 8'h11, 1'b0, 1'b1);
      check("t6_pend_cleared", {63'd0, out_valid}, 64'd0);

      // Reset mid-frame
      step(1'b1, 8'h22, 1'b0, 1'b1);
      step(1'b1, 8'h33, 1'b0, 1'b1);
      reset = 1'b1;
      step(1'b0, 8'h00, 1'b0, 1'b1);
      reset = 1'b0;
      for (int k = 0; k < 8; k++) step(1'b1, 8'(8'h50 + k), 1'b0, 1'b1);
      check("t6_after_reset", out_data, 64'h5756555453525150);
`ifdef STP_FRAME_CNT_EN
      check("t6_frame_cnt", 64'(frame_cnt), 64'd1);
`endif
      step(1'b0, 8'h00, 1'b0, 1'b1);
      step(1'b0, 8'h00, 1'b0, 1'b1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
